// File: rtl/alu_arbiter.sv
// -----------------------------------------------------------------------------
// alu_arbiter
//
// Shares a single ALU between two requesters (port 0 and port 1). Each port
// has a valid/ready request channel (op, a, b) and a valid/ready response
// channel (rc, z). One request is granted per cycle, its operands are steered
// combinationally into the ALU, and the result is captured in a one-entry
// result register that is returned only to the port that was granted.
//
// Ports:
//   i_clk, i_rst           clock, synchronous active-high reset
//   i_reqK_valid/o_reqK_ready   request handshake for port K (K = 0, 1)
//   i_reqK_op/a/b          opcode and 32-bit operands for port K
//   o_rspK_valid/i_rspK_ready   response handshake for port K
//   o_rspK_rc/o_rspK_z     33-bit result and zero flag (0 when K is not owner)
//   o_busy                 result register holds an undelivered result
//
// Parameters:
//   FAIR  1 = round-robin under contention, 0 = port 0 always wins
//   OP_W  opcode width
// -----------------------------------------------------------------------------

// -----------------------------------------------------------------------------
// alu
//
// Combinational 32-bit ALU with a 33-bit result. Bit 32 carries the carry of
// ADD and the borrow of SUB; logic/shift/compare results are zero-extended.
// o_Z flags a zero in the low 32 bits of the result.
//
// Ports:
//   i_op   opcode (codes below; unlisted codes produce 0)
//   i_Ra   operand A
//   i_Rb   operand B (bits [4:0] are the shift amount for shifts)
//   o_Rc   33-bit result
//   o_Z    o_Rc[31:0] == 0
// -----------------------------------------------------------------------------
module alu #(
  parameter int OP_W = 4
) (
  input  logic [OP_W-1:0] i_op,
  input  logic [31:0]     i_Ra,
  input  logic [31:0]     i_Rb,
  output logic [32:0]     o_Rc,
  output logic            o_Z
);

  localparam logic [OP_W-1:0] ALU_ADD   = OP_W'(0);
  localparam logic [OP_W-1:0] ALU_SUB   = OP_W'(1);
  localparam logic [OP_W-1:0] ALU_AND   = OP_W'(2);
  localparam logic [OP_W-1:0] ALU_OR    = OP_W'(3);
  localparam logic [OP_W-1:0] ALU_XOR   = OP_W'(4);
  localparam logic [OP_W-1:0] ALU_SLL   = OP_W'(5);
  localparam logic [OP_W-1:0] ALU_SRL   = OP_W'(6);
  localparam logic [OP_W-1:0] ALU_SRA   = OP_W'(7);
  localparam logic [OP_W-1:0] ALU_SLT   = OP_W'(8);
  localparam logic [OP_W-1:0] ALU_SLTU  = OP_W'(9);
  localparam logic [OP_W-1:0] ALU_PASSB = OP_W'(10);

  logic [4:0]  shamt;
  logic [31:0] sra_res;

  assign shamt   = i_Rb[4:0];
  assign sra_res = $unsigned($signed(i_Ra) >>> shamt);

  always_comb begin
    o_Rc = '0;
    case (i_op)
      // Extending both operands to 33 bits keeps carry / borrow in bit 32.
      ALU_ADD:   o_Rc = {1'b0, i_Ra} + {1'b0, i_Rb};
      ALU_SUB:   o_Rc = {1'b0, i_Ra} - {1'b0, i_Rb};
      ALU_AND:   o_Rc = {1'b0, i_Ra & i_Rb};
      ALU_OR:    o_Rc = {1'b0, i_Ra | i_Rb};
      ALU_XOR:   o_Rc = {1'b0, i_Ra ^ i_Rb};
      ALU_SLL:   o_Rc = {1'b0, i_Ra << shamt};
      ALU_SRL:   o_Rc = {1'b0, i_Ra >> shamt};
      ALU_SRA:   o_Rc = {1'b0, sra_res};
      ALU_SLT:   o_Rc = {32'd0, ($signed(i_Ra) < $signed(i_Rb))};
      ALU_SLTU:  o_Rc = {32'd0, (i_Ra < i_Rb)};
      ALU_PASSB: o_Rc = {1'b0, i_Rb};
      default:   o_Rc = '0;
    endcase
  end

  assign o_Z = (o_Rc[31:0] == 32'd0);

endmodule

module alu_arbiter #(
  parameter int FAIR = 1,
  parameter int OP_W = 4
) (
  input  logic            i_clk,
  input  logic            i_rst,

  input  logic            i_req0_valid,
  output logic            o_req0_ready,
  input  logic [OP_W-1:0] i_req0_op,
  input  logic [31:0]     i_req0_a,
  input  logic [31:0]     i_req0_b,
  output logic            o_rsp0_valid,
  input  logic            i_rsp0_ready,
  output logic [32:0]     o_rsp0_rc,
  output logic            o_rsp0_z,

  input  logic            i_req1_valid,
  output logic            o_req1_ready,
  input  logic [OP_W-1:0] i_req1_op,
  input  logic [31:0]     i_req1_a,
  input  logic [31:0]     i_req1_b,
  output logic            o_rsp1_valid,
  input  logic            i_rsp1_ready,
  output logic [32:0]     o_rsp1_rc,
  output logic            o_rsp1_z,

  output logic            o_busy
);

  // Per-port views of the flat ports so the datapath can be indexed by port.
  logic [1:0]      req_valid;
  logic [1:0]      rsp_ready;
  logic [OP_W-1:0] req_op [2];
  logic [31:0]     req_a  [2];
  logic [31:0]     req_b  [2];

  logic [1:0]      req_ready;
  logic [1:0]      rsp_valid;
  logic [32:0]     rsp_rc [2];
  logic [1:0]      rsp_z;

  assign req_valid = {i_req1_valid, i_req0_valid};
  assign rsp_ready = {i_rsp1_ready, i_rsp0_ready};
  assign req_op[0] = i_req0_op;
  assign req_op[1] = i_req1_op;
  assign req_a[0]  = i_req0_a;
  assign req_a[1]  = i_req1_a;
  assign req_b[0]  = i_req0_b;
  assign req_b[1]  = i_req1_b;

  // Result register and arbitration history.
  logic        res_valid_reg,  res_valid_next;
  logic        res_owner_reg,  res_owner_next;
  logic [32:0] res_rc_reg,     res_rc_next;
  logic        res_z_reg,      res_z_next;
  logic        last_grant_reg, last_grant_next;

  // Arbitration and ALU datapath.
  logic            winner;
  logic            slot_free;
  logic            accept;
  logic            drain;
  logic [OP_W-1:0] alu_op;
  logic [31:0]     alu_a;
  logic [31:0]     alu_b;
  logic [32:0]     alu_rc;
  logic            alu_z;

  // Winner selection. With a single requester it simply wins; under
  // contention round-robin picks the port that was not granted last.
  always_comb begin
    winner = 1'b0;
    if (req_valid[0] && req_valid[1]) begin
      winner = (FAIR != 0) ? ~last_grant_reg : 1'b0;
    end else if (req_valid[1]) begin
      winner = 1'b1;
    end
  end

  // The slot is free if empty, or if its current owner is draining it in
  // this very cycle, which lets a new result overwrite it without a bubble.
  assign slot_free = !res_valid_reg || rsp_ready[res_owner_reg];
  assign drain     = res_valid_reg && rsp_ready[res_owner_reg];
  assign accept    = req_valid[winner] && slot_free && !i_rst;

  assign alu_op = req_op[winner];
  assign alu_a  = req_a[winner];
  assign alu_b  = req_b[winner];

  alu #(
    .OP_W (OP_W)
  ) u_alu (
    .i_op (alu_op),
    .i_Ra (alu_a),
    .i_Rb (alu_b),
    .o_Rc (alu_rc),
    .o_Z  (alu_z)
  );

  always_comb begin
    res_valid_next  = res_valid_reg;
    res_owner_next  = res_owner_reg;
    res_rc_next     = res_rc_reg;
    res_z_next      = res_z_reg;
    last_grant_next = last_grant_reg;
    if (accept) begin
      res_valid_next  = 1'b1;
      res_owner_next  = winner;
      res_rc_next     = alu_rc;
      res_z_next      = alu_z;
      last_grant_next = winner;
    end else if (drain) begin
      res_valid_next  = 1'b0;
    end
  end

  // last_grant resets to 1 so that port 0 wins the first tie.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      res_valid_reg  <= 1'b0;
      res_owner_reg  <= 1'b0;
      res_rc_reg     <= '0;
      res_z_reg      <= 1'b0;
      last_grant_reg <= 1'b1;
    end else begin
      res_valid_reg  <= res_valid_next;
      res_owner_reg  <= res_owner_next;
      res_rc_reg     <= res_rc_next;
      res_z_reg      <= res_z_next;
      last_grant_reg <= last_grant_next;
    end
  end

  // Per-port handshake and result routing. Outputs are also masked while
  // i_rst is high so nothing leaks out before the first reset edge lands.
  generate
    for (genvar gi = 0; gi < 2; gi++) begin : g_port
      assign req_ready[gi] = accept && (winner == 1'(gi));
      assign rsp_valid[gi] = res_valid_reg && (res_owner_reg == 1'(gi)) && !i_rst;
      assign rsp_rc[gi]    = rsp_valid[gi] ? res_rc_reg : 33'd0;
      assign rsp_z[gi]     = rsp_valid[gi] ? res_z_reg  : 1'b0;
    end
  endgenerate

  assign o_req0_ready = req_ready[0];
  assign o_req1_ready = req_ready[1];
  assign o_rsp0_valid = rsp_valid[0];
  assign o_rsp1_valid = rsp_valid[1];
  assign o_rsp0_rc    = rsp_rc[0];
  assign o_rsp1_rc    = rsp_rc[1];
  assign o_rsp0_z     = rsp_z[0];
  assign o_rsp1_z     = rsp_z[1];
  assign o_busy       = res_valid_reg && !i_rst;

endmodule

// File: tb/tb_alu_arbiter.sv
// -----------------------------------------------------------------------------
// tb_alu_arbiter
//
// Drives a round-robin instance (FAIR=1) and a fixed-priority instance
// (FAIR=0) from the same request/response inputs. A reference model per
// instance predicts readies and responses from the arbitration rules and an
// arithmetic ALU function; directed phases add explicit value checks.
// -----------------------------------------------------------------------------
module tb_alu_arbiter;

  logic        i_clk = 1'b0;
  logic        i_rst;
  logic        i_req0_valid, i_req1_valid;
  logic [3:0]  i_req0_op, i_req1_op;
  logic [31:0] i_req0_a, i_req0_b, i_req1_a, i_req1_b;
  logic        i_rsp0_ready, i_rsp1_ready;

  // index 0 = round-robin instance, index 1 = fixed-priority instance
  logic [1:0]  req0_ready_o, req1_ready_o;
  logic [1:0]  rsp0_valid_o, rsp1_valid_o;
  logic [1:0]  rsp0_z_o, rsp1_z_o;
  logic [1:0]  busy_o;
  logic [32:0] rsp0_rc_o [2];
  logic [32:0] rsp1_rc_o [2];

  int n_checks = 0;
  int n_pass   = 0;

  int grants_rr[$];
  int grants_fp[$];

  always #5 i_clk = ~i_clk;

  alu_arbiter #(.FAIR(1), .OP_W(4)) dut_rr (
    .i_clk(i_clk), .i_rst(i_rst),
    .i_req0_valid(i_req0_valid), .o_req0_ready(req0_ready_o[0]),
    .i_req0_op(i_req0_op), .i_req0_a(i_req0_a), .i_req0_b(i_req0_b),
    .o_rsp0_valid(rsp0_valid_o[0]), .i_rsp0_ready(i_rsp0_ready),
    .o_rsp0_rc(rsp0_rc_o[0]), .o_rsp0_z(rsp0_z_o[0]),
    .i_req1_valid(i_req1_valid), .o_req1_ready(req1_ready_o[0]),
    .i_req1_op(i_req1_op), .i_req1_a(i_req1_a), .i_req1_b(i_req1_b),
    .o_rsp1_valid(rsp1_valid_o[0]), .i_rsp1_ready(i_rsp1_ready),
    .o_rsp1_rc(rsp1_rc_o[0]), .o_rsp1_z(rsp1_z_o[0]),
    .o_busy(busy_o[0])
  );

  alu_arbiter #(.FAIR(0), .OP_W(4)) dut_fp (
    .i_clk(i_clk), .i_rst(i_rst),
    .i_req0_valid(i_req0_valid), .o_req0_ready(req0_ready_o[1]),
    .i_req0_op(i_req0_op), .i_req0_a(i_req0_a), .i_req0_b(i_req0_b),
    .o_rsp0_valid(rsp0_valid_o[1]), .i_rsp0_ready(i_rsp0_ready),
    .o_rsp0_rc(rsp0_rc_o[1]), .o_rsp0_z(rsp0_z_o[1]),
    .i_req1_valid(i_req1_valid), .o_req1_ready(req1_ready_o[1]),
    .i_req1_op(i_req1_op), .i_req1_a(i_req1_a), .i_req1_b(i_req1_b),
    .o_rsp1_valid(rsp1_valid_o[1]), .i_rsp1_ready(i_rsp1_ready),
    .o_rsp1_rc(rsp1_rc_o[1]), .o_rsp1_z(rsp1_z_o[1]),
    .o_busy(busy_o[1])
  );

  task automatic check(input string tag, input logic [32:0] got, input logic [32:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s got=0x%0h expected=0x%0h", tag, got, exp);
  endtask

  // Arithmetic reference ALU: 33-bit results, carry/borrow in bit 32.
  function automatic logic [32:0] alu_ref(input logic [3:0] op, input logic [31:0] a,
                                          input logic [31:0] b);
    longint unsigned la;
    longint unsigned lb;
    int sa;
    int sb;
    la = 64'(a);
    lb = 64'(b);
    sa = int'(a);
    sb = int'(b);
    case (op)
      4'd0:    return 33'(la + lb);
      4'd1:    return 33'(la - lb);
      4'd2:    return {1'b0, a & b};
      4'd3:    return {1'b0, a | b};
      4'd4:    return {1'b0, a ^ b};
      4'd5:    return {1'b0, a << b[4:0]};
      4'd6:    return {1'b0, a >> b[4:0]};
      4'd7:    return {1'b0, 32'(sa >>> b[4:0])};
      4'd8:    return (sa < sb) ? 33'd1 : 33'd0;
      4'd9:    return (la < lb) ? 33'd1 : 33'd0;
      4'd10:   return {1'b0, b};
      default: return 33'd0;
    endcase
  endfunction

  // Reference model: one optional held result per instance plus last grant.
  logic        m_valid [2];
  logic        m_owner [2];
  logic [32:0] m_rc    [2];
  logic        m_last  [2];

  always @(negedge i_clk) begin
    string nm;
    logic sfree, win, e_r0, e_r1, e_v0, e_v1;
    for (int d = 0; d < 2; d++) begin
      nm = (d == 0) ? "rr" : "fp";
      if (i_rst) begin
        check({nm, ".rst_ready0"}, 33'(req0_ready_o[d]), 33'd0);
        check({nm, ".rst_ready1"}, 33'(req1_ready_o[d]), 33'd0);
        check({nm, ".rst_rsp0_valid"}, 33'(rsp0_valid_o[d]), 33'd0);
        check({nm, ".rst_rsp1_valid"}, 33'(rsp1_valid_o[d]), 33'd0);
        check({nm, ".rst_busy"}, 33'(busy_o[d]), 33'd0);
        m_valid[d] = 1'b0;
        m_owner[d] = 1'b0;
        m_rc[d]    = 33'd0;
        m_last[d]  = 1'b1;
      end else begin
        sfree = !m_valid[d] || (m_owner[d] ? i_rsp1_ready : i_rsp0_ready);
        if (i_req0_valid && i_req1_valid) win = (d == 0) ? !m_last[d] : 1'b0;
        else win = i_req1_valid;
        e_r0 = sfree && i_req0_valid && !win;
        e_r1 = sfree && i_req1_valid && win;
        e_v0 = m_valid[d] && !m_owner[d];
        e_v1 = m_valid[d] && m_owner[d];
        check({nm, ".ready0"}, 33'(req0_ready_o[d]), 33'(e_r0));
        check({nm, ".ready1"}, 33'(req1_ready_o[d]), 33'(e_r1));
        check({nm, ".rsp0_valid"}, 33'(rsp0_valid_o[d]), 33'(e_v0));
        check({nm, ".rsp1_valid"}, 33'(rsp1_valid_o[d]), 33'(e_v1));
        check({nm, ".rsp0_rc"}, rsp0_rc_o[d], e_v0 ? m_rc[d] : 33'd0);
        check({nm, ".rsp1_rc"}, rsp1_rc_o[d], e_v1 ? m_rc[d] : 33'd0);
        check({nm, ".rsp0_z"}, 33'(rsp0_z_o[d]), 33'(e_v0 && (m_rc[d][31:0] == 32'd0)));
        check({nm, ".rsp1_z"}, 33'(rsp1_z_o[d]), 33'(e_v1 && (m_rc[d][31:0] == 32'd0)));
        check({nm, ".busy"}, 33'(busy_o[d]), 33'(m_valid[d]));
        if (req0_ready_o[d]) begin
          if (d == 0) grants_rr.push_back(0); else grants_fp.push_back(0);
        end
        if (req1_ready_o[d]) begin
          if (d == 0) grants_rr.push_back(1); else grants_fp.push_back(1);
        end
        if (e_r0 || e_r1) begin
          m_valid[d] = 1'b1;
          m_owner[d] = win;
          m_rc[d]    = win ? alu_ref(i_req1_op, i_req1_a, i_req1_b)
                           : alu_ref(i_req0_op, i_req0_a, i_req0_b);
          m_last[d]  = win;
        end else if (m_valid[d] && (m_owner[d] ? i_rsp1_ready : i_rsp0_ready)) begin
          m_valid[d] = 1'b0;
        end
      end
    end
  end

  task automatic to_neg();
    @(negedge i_clk);
  endtask

  task automatic to_pos();
    @(posedge i_clk);
    #1;
  endtask

  task automatic set_req(input int p, input logic v, input logic [3:0] op,
                         input logic [31:0] a, input logic [31:0] b);
    if (p == 0) begin
      i_req0_valid = v; i_req0_op = op; i_req0_a = a; i_req0_b = b;
    end else begin
      i_req1_valid = v; i_req1_op = op; i_req1_a = a; i_req1_b = b;
    end
  endtask

  function automatic logic [31:0] rand_operand();
    if ($urandom_range(0, 3) == 0) return 32'($urandom_range(0, 3));
    return 32'($urandom);
  endfunction

  initial begin
    logic hold0, hold1;
    i_rst = 1'b1;
    set_req(0, 1'b1, 4'd0, 32'd1, 32'd2);
    set_req(1, 1'b1, 4'd0, 32'd3, 32'd4);
    i_rsp0_ready = 1'b1;
    i_rsp1_ready = 1'b1;

    // Reset held with both requests valid.
    to_pos();
    for (int i = 0; i < 3; i++) begin
      to_neg();
      check("reset.ready0", 33'(req0_ready_o[0]), 33'd0);
      check("reset.ready1", 33'(req1_ready_o[0]), 33'd0);
      to_pos();
    end
    i_rst = 1'b0;
    to_neg();
    check("first_tie.rr_ready0", 33'(req0_ready_o[0]), 33'd1);
    check("first_tie.rr_ready1", 33'(req1_ready_o[0]), 33'd0);
    check("first_tie.fp_ready0", 33'(req0_ready_o[1]), 33'd1);
    to_pos();
    set_req(0, 1'b0, 4'd0, 32'd0, 32'd0);
    set_req(1, 1'b0, 4'd0, 32'd0, 32'd0);
    to_neg();
    to_pos();

    // Port 0 ADD 5 + 7.
    set_req(0, 1'b1, 4'd0, 32'd5, 32'd7);
    to_neg();
    check("add.ready0", 33'(req0_ready_o[0]), 33'd1);
    to_pos();
    set_req(0, 1'b0, 4'd0, 32'd0, 32'd0);
    to_neg();
    check("add.rsp0_valid", 33'(rsp0_valid_o[0]), 33'd1);
    check("add.rsp0_rc", rsp0_rc_o[0], 33'd12);
    check("add.rsp0_z", 33'(rsp0_z_o[0]), 33'd0);
    check("add.rsp1_valid", 33'(rsp1_valid_o[0]), 33'd0);
    to_pos();

    // Port 1 SUB 9 - 9 sets the zero flag.
    set_req(1, 1'b1, 4'd1, 32'd9, 32'd9);
    to_neg();
    check("sub.ready1", 33'(req1_ready_o[0]), 33'd1);
    to_pos();
    set_req(1, 1'b0, 4'd0, 32'd0, 32'd0);
    to_neg();
    check("sub.rsp1_valid", 33'(rsp1_valid_o[0]), 33'd1);
    check("sub.rsp1_rc", rsp1_rc_o[0], 33'd0);
    check("sub.rsp1_z", 33'(rsp1_z_o[0]), 33'd1);
    to_pos();

    // Continuous contention for 6 cycles.
    grants_rr.delete();
    grants_fp.delete();
    set_req(0, 1'b1, 4'd0, 32'd100, 32'd1);
    set_req(1, 1'b1, 4'd0, 32'd200, 32'd2);
    repeat (6) begin
      to_neg();
      to_pos();
    end
    set_req(0, 1'b0, 4'd0, 32'd0, 32'd0);
    set_req(1, 1'b0, 4'd0, 32'd0, 32'd0);
    to_neg();
    to_pos();
    check("contend.rr_count", 33'(grants_rr.size()), 33'd6);
    check("contend.fp_count", 33'(grants_fp.size()), 33'd6);
    for (int i = 0; i < 6; i++) begin
      if (i < grants_rr.size()) check($sformatf("contend.rr_grant%0d", i), 33'(grants_rr[i]), 33'(i % 2));
      if (i < grants_fp.size()) check($sformatf("contend.fp_grant%0d", i), 33'(grants_fp[i]), 33'd0);
    end

    // Backpressure on port 0 while port 1 waits.
    i_rsp0_ready = 1'b0;
    set_req(0, 1'b1, 4'd4, 32'hF0F0F0F0, 32'hFFFFFFFF);
    to_neg();
    check("bp.ready0", 33'(req0_ready_o[0]), 33'd1);
    to_pos();
    set_req(0, 1'b0, 4'd0, 32'd0, 32'd0);
    set_req(1, 1'b1, 4'd0, 32'd3, 32'd4);
    for (int i = 0; i < 4; i++) begin
      to_neg();
      check("bp.rsp0_valid", 33'(rsp0_valid_o[0]), 33'd1);
      check("bp.rsp0_rc", rsp0_rc_o[0], 33'h0_0F0F0F0F);
      check("bp.ready0", 33'(req0_ready_o[0]), 33'd0);
      check("bp.ready1", 33'(req1_ready_o[0]), 33'd0);
      check("bp.busy", 33'(busy_o[0]), 33'd1);
      to_pos();
    end
    i_rsp0_ready = 1'b1;
    to_neg();
    check("bp.release_ready1", 33'(req1_ready_o[0]), 33'd1);
    to_pos();
    set_req(1, 1'b0, 4'd0, 32'd0, 32'd0);
    to_neg();
    check("bp.rsp1_valid", 33'(rsp1_valid_o[0]), 33'd1);
    check("bp.rsp1_rc", rsp1_rc_o[0], 33'd7);
    check("bp.rsp0_valid", 33'(rsp0_valid_o[0]), 33'd0);
    to_pos();

    // Reset during the response cycle discards the result.
    i_rsp1_ready = 1'b0;
    set_req(1, 1'b1, 4'd9, 32'd1, 32'd2);
    to_neg();
    check("rstmid.ready1", 33'(req1_ready_o[0]), 33'd1);
    to_pos();
    set_req(1, 1'b0, 4'd0, 32'd0, 32'd0);
    i_rst = 1'b1;
    to_neg();
    check("rstmid.rsp1_valid_in_rst", 33'(rsp1_valid_o[0]), 33'd0);
    to_pos();
    i_rst = 1'b0;
    i_rsp1_ready = 1'b1;
    repeat (2) begin
      to_neg();
      check("rstmid.rsp1_valid", 33'(rsp1_valid_o[0]), 33'd0);
      check("rstmid.busy", 33'(busy_o[0]), 33'd0);
      to_pos();
    end

    // Randomized traffic against the model, honouring hold-until-ready.
    for (int c = 0; c < 500; c++) begin
      to_neg();
      hold0 = i_req0_valid && !req0_ready_o[0] && !i_rst;
      hold1 = i_req1_valid && !req1_ready_o[0] && !i_rst;
      to_pos();
      i_rst = ($urandom_range(0, 99) == 0);
      if (!hold0 || $urandom_range(0, 7) == 0)
        set_req(0, ($urandom_range(0, 9) < 7), 4'($urandom_range(0, 15)), rand_operand(), rand_operand());
      if (!hold1 || $urandom_range(0, 7) == 0)
        set_req(1, ($urandom_range(0, 9) < 7), 4'($urandom_range(0, 15)), rand_operand(), rand_operand());
      i_rsp0_ready = ($urandom_range(0, 3) != 0);
      i_rsp1_ready = ($urandom_range(0, 3) != 0);
    end

    to_neg();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/alu_arbiter.md
Name: alu_arbiter

Overview:
- Shares one ALU instance between two requesters, e.g. port 0 = execute stage and port 1 = address-generation/CSR helper.
- Each requester has a valid/ready request channel and a valid/ready response channel.
- The block arbitrates, drives the internal ALU, registers the result, and returns it to the port that was granted.
- Sustains one operation per cycle when responses drain immediately.

Parameters:
- FAIR, 1: 1 = round-robin between ports; 0 = fixed priority, port 0 wins.
- OP_W, 4: ALU opcode width; codes per ALU_DEFINES.vh.

Ports:
- i_clk  in  1  clock
- i_rst  in  1  synchronous active-high reset
- i_req0_valid  in  1  port 0 request valid
- o_req0_ready  out  1  port 0 request accepted this cycle
- i_req0_op  in  OP_W  port 0 opcode
- i_req0_a  in  32  port 0 operand Ra
- i_req0_b  in  32  port 0 operand Rb
- o_rsp0_valid  out  1  port 0 result valid
- i_rsp0_ready  in  1  port 0 result consumed
- o_rsp0_rc  out  33  port 0 result (ALU o_Rc)
- o_rsp0_z  out  1  port 0 zero flag (ALU o_Z)
- i_req1_valid, o_req1_ready, i_req1_op, i_req1_a, i_req1_b, o_rsp1_valid, i_rsp1_ready, o_rsp1_rc, o_rsp1_z: same as port 0, for port 1
- o_busy  out  1  result register occupied

Behaviour:
- Contains one ALU instance (i_op, i_Ra, i_Rb, o_Rc, o_Z). Its inputs are muxed combinationally from the winning port.
- State: res_valid, res_owner (0/1), res_rc[32:0], res_z, last_grant.

Reset (i_rst=1 at a clock edge):
- res_valid=0, res_owner=0, res_rc=0, res_z=0, last_grant=1, so port 0 wins the first tie.
- While i_rst=1: o_req*_ready=0, o_rsp*_valid=0, o_busy=0.
- Reset mid-operation discards any held result; it is never delivered.

Arbitration (combinational):
- One valid request: that port wins.
- Both valid, FAIR=1: the port != last_grant wins.
- Both valid, FAIR=0: port 0 wins.

Accept condition:
- slot_free = !res_valid || (rsp_ready of res_owner).
- o_reqK_ready = winner==K && i_reqK_valid && slot_free.
- At most one ready is high per cycle.

Accept (posedge with ready high):
- res_rc/res_z <= ALU outputs for the winner's op/a/b.
- res_owner <= K, res_valid <= 1, last_grant <= K.
- Latency: request accepted at edge N, response valid after edge N, i.e. in cycle N+1.

Response:
- o_rspK_valid = res_valid && res_owner==K.
- o_rspK_rc/o_rspK_z = res_rc/res_z for the owner; 0 for the non-owner.
- Held stable until the owner's rsp_ready is sampled high.
- Drain without a new accept: res_valid <= 0.
- Drain and accept in the same cycle: the register is overwritten, no bubble.
- rsp_ready of the non-owner is ignored.

Protocol and data rules:
- A requester holds valid/op/a/b stable until ready. Dropping valid before ready is legal; the request simply disappears and no response is generated.
- last_grant changes only on accept. Under FAIR=1 with continuous contention, grants strictly alternate.
- Unknown opcodes are passed to the ALU unmodified; the result is whatever the ALU produces.
- The 33-bit result is passed through without truncation.
- o_busy = res_valid.

Test Plan:
- Reset: hold i_rst 3 cycles with both requests valid -> both readys 0, both rsp_valid 0. First edge after reset, both valid -> port 0 granted.
- Port 0 single op: ALU_ADD a=5, b=7, i_rsp0_ready=1 -> o_req0_ready=1 in cycle N; o_rsp0_valid=1, o_rsp0_rc=12, o_rsp0_z=0 in cycle N+1; o_rsp1_valid stays 0.
- Zero flag: port 1 ALU_SUB a=9, b=9 -> o_rsp1_rc=0, o_rsp1_z=1.
- FAIR=1 contention: both ports continuously valid, both rsp_ready=1, 6 cycles -> grants 0,1,0,1,0,1; one response per cycle, each routed to the correct owner.
- Backpressure: port 0 ALU_XOR a=0xF0F0F0F0, b=0xFFFFFFFF with i_rsp0_ready=0 for 4 cycles and port 1 valid:
  - Result 0x00F0F0F0F held stable; both readys 0; o_busy=1.
  - Raise i_rsp0_ready -> same cycle o_req1_ready=1, and the next cycle o_rsp1_valid=1.
- Reset mid-operation: accept port 1 ALU_SLTU a=1, b=2, assert i_rst in the response cycle with rsp_ready=0 -> o_rsp1_valid=0 after reset and no stale result. FAIR=0 rerun of contention -> port 0 always granted.
